// File: rtl/sipo_frame_rx_pkg.sv
// Shared definitions for the PISO/SIPO pair: FSM state encodings and the default word width.
package sipo_frame_rx_pkg;

  localparam int SIPO_DEFAULT_WIDTH = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

endpackage

// File: rtl/sipo_frame_rx_shift_core.sv
// Shift register and bit counter for the SIPO receiver; flags the bit that completes a word.
module sipo_shift_core import sipo_frame_rx_pkg::*; #(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             restart,
  output logic [WIDTH-1:0] word,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    count;

  // A restart bit always begins a new word, so it can never be the completing bit.
  always_comb begin
    word      = {sreg[WIDTH-2:0], serial_in};
    word_done = shift_en && !restart && (count == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg  <= '0;
      count <= '0;
    end else if (shift_en) begin
      if (restart) begin
        sreg  <= {{(WIDTH-1){1'b0}}, serial_in};
        count <= CNT_ONE;
      end else if (word_done) begin
        sreg  <= word;
        count <= '0;
      end else begin
        sreg  <= word;
        count <= count + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/sipo_frame_rx.sv
// SIPO frame receiver: framing FSM, one-entry valid/ready output buffer and sticky error flags.
module sipo_frame_rx import sipo_frame_rx_pkg::*; #(
  parameter int WIDTH      = SIPO_DEFAULT_WIDTH,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overflow,
  output logic             frame_err
);

  logic             state;
  logic             state_next;
  logic             seen_word;
  logic             shift_en;
  logic             restart;
  logic             word_done;
  logic             load;
  logic [WIDTH-1:0] word;

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .shift_en  (shift_en),
    .restart   (restart),
    .word      (word),
    .word_done (word_done)
  );

  // In IDLE only frame_start opens a word, unless continuous mode has already locked on.
  always_comb begin
    restart    = serial_valid && frame_start;
    shift_en   = serial_valid &&
                 ((state == ST_SHIFT) || frame_start || (CONTINUOUS && seen_word));
    state_next = state;
    if (shift_en) begin
      state_next = word_done ? ST_IDLE : ST_SHIFT;
    end
    load = word_done && (!out_valid || out_ready);
  end

  assign busy = (state == ST_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      seen_word <= 1'b0;
    end else begin
      state <= state_next;
      if (word_done) begin
        seen_word <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      parallel_out <= '0;
    end else if (load) begin
      out_valid    <= 1'b1;
      parallel_out <= word;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear takes priority over a set arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (clear_flags) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (word_done && out_valid && !out_ready) begin
        overflow <= 1'b1;
      end
      if (restart && (state == ST_SHIFT)) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx (WIDTH=4, CONTINUOUS=0) with an expected-word scoreboard.
module tb_sipo_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b0;
  logic       serial_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic       out_ready = 1'b1;
  logic       clear_flags = 1'b0;
  logic [3:0] parallel_out;
  logic       out_valid;
  logic       busy;
  logic       overflow;
  logic       frame_err;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] sb[$];

  sipo_frame_rx #(.WIDTH(4), .CONTINUOUS(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .out_ready    (out_ready),
    .clear_flags  (clear_flags),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overflow     (overflow),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Every accepted word must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_output("spurious_word", 32'(parallel_out), 32'hFFFF_FFFF);
      end else begin
        check_output("sb_word", 32'(parallel_out), 32'(sb.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic fs);
    serial_in    = b;
    serial_valid = 1'b1;
    frame_start  = fs;
    @(posedge clk);
    #1;
    serial_valid = 1'b0;
    frame_start  = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] w, input int gap, input bit expect_word);
    if (expect_word) sb.push_back(w);
    for (int i = 3; i >= 0; i--) begin
      send_bit(w[i], i == 3);
      if (i != 0) idle(gap);
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_out_valid", 32'(out_valid), 0);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_parallel", 32'(parallel_out), 0);
    check_output("rst_flags", 32'({overflow, frame_err}), 0);
    rst = 1'b0;
    idle(1);

    // Qualified bits without frame_start are ignored
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check_output("nostart_busy", 32'(busy), 0);
    idle(1);
    check_output("nostart_valid", 32'(out_valid), 0);

    // Basic back-to-back frame
    send_bit(1'b1, 1'b1);
    check_output("basic_busy", 32'(busy), 1);
    sb.push_back(4'b1011);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check_output("basic_valid", 32'(out_valid), 1);
    check_output("basic_word", 32'(parallel_out), 32'h0000_000B);
    check_output("basic_busy_done", 32'(busy), 0);
    idle(2);

    // Frame with 3-cycle gaps between bits
    send_frame(4'b1011, 3, 1'b1);
    check_output("gap_word", 32'(parallel_out), 32'h0000_000B);
    check_output("gap_flags", 32'({overflow, frame_err}), 0);
    idle(2);

    // Backpressure: second word dropped, first word held
    out_ready = 1'b0;
    send_frame(4'b1011, 0, 1'b1);
    idle(1);
    send_frame(4'b0110, 0, 1'b0);
    idle(1);
    check_output("bp_word_held", 32'(parallel_out), 32'h0000_000B);
    check_output("bp_valid", 32'(out_valid), 1);
    check_output("bp_overflow", 32'(overflow), 1);
    out_ready = 1'b1;
    idle(1);
    check_output("bp_valid_drop", 32'(out_valid), 0);
    check_output("bp_overflow_sticky", 32'(overflow), 1);
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    check_output("bp_overflow_clr", 32'(overflow), 0);

    // Abort a partial frame with a new frame_start
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_frame(4'b0101, 0, 1'b1);
    check_output("abort_frame_err", 32'(frame_err), 1);
    check_output("abort_word", 32'(parallel_out), 32'h0000_0005);
    check_output("abort_overflow", 32'(overflow), 0);
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    check_output("abort_clr", 32'(frame_err), 0);

    // Reset in the middle of a frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    check_output("mid_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    #2;
    check_output("mid_busy_rst", 32'(busy), 0);
    check_output("mid_count_rst", 32'(dut.u_core.count), 0);
    check_output("mid_valid_rst", 32'(out_valid), 0);
    rst = 1'b0;
    idle(1);
    send_frame(4'b1001, 0, 1'b1);
    check_output("mid_word", 32'(parallel_out), 32'h0000_0009);
    check_output("mid_flags", 32'({overflow, frame_err}), 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    check_output("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
